stream_scale_lanes: RTL and testbench

STREAM_SCALE_LANES -- requirements
Module: stream_scale_lanes

---
 rtl/stream_scale_lanes_if.sv | 31 +++
 rtl/stream_scale_lanes.sv | 174 +++++++++++++++++
 tb/tb_stream_scale_lanes.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_scale_lanes_if.sv
// -----------------------------------------------------------------------------
// stream_scale_lanes_if
// Purpose : one direction of a valid/ack word stream with a separate "last"
//           flag. The value and last channels each carry their own vld/ack
//           pair so the bundle matches the block-level stream naming.
// Signals : value_V          word payload, DW bits
//           last_V           end-of-run marker for the same word
//           *_ap_vld         producer says the word is present
//           *_ap_ack         consumer takes the word
// Modports: master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface stream_scale_lanes_if #(
  parameter int DW = 8
);
  logic [DW-1:0] value_V;
  logic          last_V;
  logic          value_V_ap_vld;
  logic          last_V_ap_vld;
  logic          value_V_ap_ack;
  logic          last_V_ap_ack;

  modport master (
    output value_V, last_V, value_V_ap_vld, last_V_ap_vld,
    input  value_V_ap_ack, last_V_ap_ack
  );

  modport slave (
    input  value_V, last_V, value_V_ap_vld, last_V_ap_vld,
    output value_V_ap_ack, last_V_ap_ack
  );
endinterface

// File: rtl/stream_scale_lanes.sv
// -----------------------------------------------------------------------------
// stream_scale_lanes
// Purpose : multiplies every WIDTH-bit lane of each incoming stream word by a
//           per-run unsigned scale factor and forwards the result through a
//           2-entry FIFO. SATURATE selects clamping or truncation of results.
// Ports   : ap_clk, ap_rst      clock and synchronous active-high reset
//           ap_start            begin a run (sampled in IDLE only)
//           ap_done/ap_ready    one-cycle pulses: run finished / input closed
//           ap_idle             high while in IDLE
//           scale               multiplier, latched when a run starts
//           hw_input_V          input stream (slave side)
//           hw_output_V         output stream (master side)
//           beat_count          output words delivered in current/last run
// -----------------------------------------------------------------------------
module stream_scale_lanes #(
  parameter int WIDTH    = 8,
  parameter int LANES    = 1,
  parameter int SCALE_W  = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [SCALE_W-1:0]   scale,
  stream_scale_lanes_if.slave  hw_input_V,
  stream_scale_lanes_if.master hw_output_V,
  output logic [31:0]          beat_count
);

  localparam int DW = WIDTH * LANES;
  localparam int PW = WIDTH + SCALE_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SCALE_W-1:0] r_scale;
  logic [DW-1:0]      r_mem_data [2];
  logic [1:0]         r_mem_last;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_occ;
  logic               r_done;
  logic               r_ready;
  logic [31:0]        r_beat_count;

  logic               w_in_ack;
  logic               w_out_vld;
  logic               w_push;
  logic               w_pop;
  logic               w_start;
  logic               w_ready_set;
  logic               w_done_set;
  logic [DW-1:0]      w_scaled;

  // Input acks depend only on registered state, so there is no combinational
  // path from the downstream acks back to the upstream producer.
  assign w_in_ack  = (r_state == S_RUN) && (r_occ < 2'd2);
  assign w_out_vld = (r_occ != 2'd0);
  assign w_push    = w_in_ack && hw_input_V.value_V_ap_vld && hw_input_V.last_V_ap_vld;
  assign w_pop     = w_out_vld && hw_output_V.value_V_ap_ack && hw_output_V.last_V_ap_ack;

  // Scaling happens on the way into the FIFO so the stored word is final.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      if (SATURATE) begin : g_sat
        logic [PW-1:0] w_prod;
        assign w_prod = PW'(hw_input_V.value_V[gi*WIDTH +: WIDTH]) * PW'(r_scale);
        assign w_scaled[gi*WIDTH +: WIDTH] =
          (w_prod > PW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : w_prod[WIDTH-1:0];
      end else begin : g_trunc
        assign w_scaled[gi*WIDTH +: WIDTH] =
          WIDTH'(PW'(hw_input_V.value_V[gi*WIDTH +: WIDTH]) * PW'(r_scale));
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_ready_set  = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_state_next = S_RUN;
          w_start      = 1'b1;
        end
      end
      S_RUN: begin
        if (w_push && hw_input_V.last_V) begin
          w_state_next = S_DRAIN;
          w_ready_set  = 1'b1;
        end
      end
      S_DRAIN: begin
        // The word marked last is the newest in the FIFO, so popping it
        // leaves the FIFO empty for the next run.
        if (w_pop && r_mem_last[r_rd_ptr]) begin
          w_state_next = S_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_scale       <= '0;
      r_mem_data[0] <= '0;
      r_mem_data[1] <= '0;
      r_mem_last    <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_occ         <= 2'd0;
      r_done        <= 1'b0;
      r_ready       <= 1'b0;
      r_beat_count  <= '0;
    end else begin
      r_done  <= w_done_set;
      r_ready <= w_ready_set;

      if (w_start) begin
        r_scale      <= scale;
        r_beat_count <= '0;
      end else if (w_pop) begin
        r_beat_count <= r_beat_count + 32'd1;
      end

      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_scaled;
        r_mem_last[r_wr_ptr] <= hw_input_V.last_V;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      // Simultaneous push and pop keeps the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign hw_input_V.value_V_ap_ack  = w_in_ack;
  assign hw_input_V.last_V_ap_ack   = w_in_ack;

  // Gate the head entry with vld so an empty FIFO presents zeros.
  assign hw_output_V.value_V_ap_vld = w_out_vld;
  assign hw_output_V.last_V_ap_vld  = w_out_vld;
  assign hw_output_V.value_V        = w_out_vld ? r_mem_data[r_rd_ptr] : '0;
  assign hw_output_V.last_V         = w_out_vld ? r_mem_last[r_rd_ptr] : 1'b0;

  assign ap_idle    = (r_state == S_IDLE);
  assign ap_done    = r_done;
  assign ap_ready   = r_ready;
  assign beat_count = r_beat_count;

endmodule

// File: tb/tb_stream_scale_lanes.sv
module tb_stream_scale_lanes;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic [7:0]  scale;
  logic [31:0] in_value;
  logic        in_last;
  logic        in_vld;
  logic        out_ack;

  logic        done0, idle0, ready0, done1, idle1, ready1;
  logic [31:0] beat0, beat1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ap_clk = ~ap_clk;

  // dut0: one lane, truncating. dut1: four lanes, saturating.
  stream_scale_lanes_if #(.DW(8))  in0  ();
  stream_scale_lanes_if #(.DW(8))  out0 ();
  stream_scale_lanes_if #(.DW(32)) in1  ();
  stream_scale_lanes_if #(.DW(32)) out1 ();

  assign in0.value_V        = in_value[7:0];
  assign in0.last_V         = in_last;
  assign in0.value_V_ap_vld = in_vld;
  assign in0.last_V_ap_vld  = in_vld;
  assign in1.value_V        = in_value;
  assign in1.last_V         = in_last;
  assign in1.value_V_ap_vld = in_vld;
  assign in1.last_V_ap_vld  = in_vld;
  assign out0.value_V_ap_ack = out_ack;
  assign out0.last_V_ap_ack  = out_ack;
  assign out1.value_V_ap_ack = out_ack;
  assign out1.last_V_ap_ack  = out_ack;

  stream_scale_lanes #(.WIDTH(8), .LANES(1), .SCALE_W(8), .SATURATE(1'b0)) dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(done0), .ap_idle(idle0), .ap_ready(ready0),
    .scale(scale), .hw_input_V(in0), .hw_output_V(out0), .beat_count(beat0)
  );

  stream_scale_lanes #(.WIDTH(8), .LANES(4), .SCALE_W(8), .SATURATE(1'b1)) dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(done1), .ap_idle(idle1), .ap_ready(ready1),
    .scale(scale), .hw_input_V(in1), .hw_output_V(out1), .beat_count(beat1)
  );

  typedef struct {
    logic [7:0]  scale;
    logic [31:0] value;
    logic [31:0] exp0;   // 1 lane, truncated
    logic [31:0] exp1;   // 4 lanes, saturated
  } vec_t;

  vec_t vecs[8];

  // Reference: per-lane unsigned product, clamped or truncated to 8 bits.
  function automatic logic [31:0] model(input logic [31:0] v, input logic [7:0] s,
                                        input int lanes, input bit sat);
    logic [31:0] r;
    logic [15:0] p;
    r = '0;
    for (int k = 0; k < lanes; k++) begin
      p = 16'(v[k*8 +: 8]) * 16'(s);
      r[k*8 +: 8] = (sat && p > 16'd255) ? 8'hFF : p[7:0];
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input bit e_idle, input bit e_rdy,
                          input bit e_done, input bit e_iack, input int e_beat);
    chk({tag, "/idle0"},  32'(idle0),  32'(e_idle));
    chk({tag, "/idle1"},  32'(idle1),  32'(e_idle));
    chk({tag, "/ready0"}, 32'(ready0), 32'(e_rdy));
    chk({tag, "/ready1"}, 32'(ready1), 32'(e_rdy));
    chk({tag, "/done0"},  32'(done0),  32'(e_done));
    chk({tag, "/done1"},  32'(done1),  32'(e_done));
    chk({tag, "/iack0"},  32'({in0.value_V_ap_ack, in0.last_V_ap_ack}), e_iack ? 32'd3 : 32'd0);
    chk({tag, "/iack1"},  32'({in1.value_V_ap_ack, in1.last_V_ap_ack}), e_iack ? 32'd3 : 32'd0);
    chk({tag, "/beat0"},  beat0, 32'(e_beat));
    chk({tag, "/beat1"},  beat1, 32'(e_beat));
  endtask

  task automatic chk_out(input string tag, input bit e_vld, input logic [31:0] e0,
                         input logic [31:0] e1, input bit e_last);
    chk({tag, "/vld0"},  32'({out0.value_V_ap_vld, out0.last_V_ap_vld}), e_vld ? 32'd3 : 32'd0);
    chk({tag, "/vld1"},  32'({out1.value_V_ap_vld, out1.last_V_ap_vld}), e_vld ? 32'd3 : 32'd0);
    chk({tag, "/data0"}, 32'(out0.value_V), e0);
    chk({tag, "/data1"}, out1.value_V, e1);
    chk({tag, "/last0"}, 32'(out0.last_V), 32'(e_last));
    chk({tag, "/last1"}, 32'(out1.last_V), 32'(e_last));
  endtask

  task automatic start_run(input logic [7:0] s);
    scale    = s;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  initial begin
    logic [31:0] w [4];

    vecs[0] = '{8'd5,   32'h0000000A, 32'h00000032, 32'h00000032};
    vecs[1] = '{8'd5,   32'h0000003C, 32'h0000002C, 32'h000000FF};
    vecs[2] = '{8'd3,   32'h04030201, 32'h00000003, 32'h0C090603};
    vecs[3] = '{8'd0,   32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[4] = '{8'd1,   32'h80FF7F01, 32'h00000001, 32'h80FF7F01};
    vecs[5] = '{8'd255, 32'h00020001, 32'h000000FF, 32'h00FF00FF};
    vecs[6] = '{8'd2,   32'h81408000, 32'h00000000, 32'hFF80FF00};
    vecs[7] = '{8'd16,  32'h00000011, 32'h00000010, 32'h000000FF};

    ap_rst = 1'b1; ap_start = 1'b0; scale = '0;
    in_value = '0; in_last = 1'b0; in_vld = 1'b0; out_ack = 1'b0;
    tick(); tick();
    chk_ctrl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    ap_rst = 1'b0;
    out_ack = 1'b1;
    tick();
    chk_ctrl("idle_ack", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    $display("reset: checks so far %0d", n_checks);

    // Single-word runs from the vector table.
    for (int i = 0; i < 8; i++) begin
      out_ack = 1'b1;
      start_run(vecs[i].scale);
      chk_ctrl("vec_run", 1'b0, 1'b0, 1'b0, 1'b1, 0);
      in_value = vecs[i].value; in_last = 1'b1; in_vld = 1'b1;
      tick();
      in_vld = 1'b0;
      chk_out("vec_out", 1'b1, vecs[i].exp0, vecs[i].exp1, 1'b1);
      chk_ctrl("vec_rdy", 1'b0, 1'b1, 1'b0, 1'b0, 0);
      tick();
      chk_ctrl("vec_done", 1'b1, 1'b0, 1'b1, 1'b0, 1);
      chk_out("vec_empty", 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      chk_ctrl("vec_after", 1'b1, 1'b0, 1'b0, 1'b0, 1);
      $display("vec %0d: scale=%0d in=%08h out0=%0h out1=%08h", i, vecs[i].scale,
               vecs[i].value, vecs[i].exp0, vecs[i].exp1);
    end

    // Eight-word run, acks always high: one word per cycle, no bubbles.
    out_ack = 1'b1;
    start_run(8'd5);
    for (int k = 0; k < 8; k++) begin
      in_value = {8'(200 + k), 8'(3 * k), 8'(k + 1), 8'(10 * (k + 1))};
      in_last  = (k == 7);
      in_vld   = 1'b1;
      chk("burst/iack0", 32'(in0.value_V_ap_ack), 32'd1);
      chk("burst/iack1", 32'(in1.value_V_ap_ack), 32'd1);
      tick();
      chk_out("burst_out", 1'b1, model(in_value, 8'd5, 1, 1'b0),
              model(in_value, 8'd5, 4, 1'b1), k == 7);
      chk_ctrl("burst_ctl", 1'b0, k == 7, 1'b0, k != 7, k);
      $display("burst word %0d: in=%08h out0=%0h", k, in_value, out0.value_V);
    end
    in_vld = 1'b0;
    tick();
    chk_ctrl("burst_done", 1'b1, 1'b0, 1'b1, 1'b0, 8);
    tick();
    chk_ctrl("burst_after", 1'b1, 1'b0, 1'b0, 1'b0, 8);

    // Backpressure: two words buffered, third held off until space frees.
    for (int k = 1; k <= 3; k++) w[k] = {16'h0, 8'(k * 50), 8'(k)};
    out_ack = 1'b0;
    start_run(8'd3);
    in_value = w[1]; in_last = 1'b0; in_vld = 1'b1;
    tick();
    chk_out("bp_w1", 1'b1, model(w[1], 8'd3, 1, 1'b0), model(w[1], 8'd3, 4, 1'b1), 1'b0);
    chk_ctrl("bp_1", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    in_value = w[2];
    tick();
    chk_ctrl("bp_full", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    in_value = w[3]; in_last = 1'b1;
    for (int h = 0; h < 2; h++) begin
      tick();
      chk_out("bp_hold", 1'b1, model(w[1], 8'd3, 1, 1'b0), model(w[1], 8'd3, 4, 1'b1), 1'b0);
      chk_ctrl("bp_stall", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    out_ack = 1'b1;
    tick();
    chk_out("bp_w2", 1'b1, model(w[2], 8'd3, 1, 1'b0), model(w[2], 8'd3, 4, 1'b1), 1'b0);
    chk_ctrl("bp_pop1", 1'b0, 1'b0, 1'b0, 1'b1, 1);
    tick();
    in_vld = 1'b0;
    chk_out("bp_w3", 1'b1, model(w[3], 8'd3, 1, 1'b0), model(w[3], 8'd3, 4, 1'b1), 1'b1);
    chk_ctrl("bp_pushpop", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    tick();
    chk_ctrl("bp_done", 1'b1, 1'b0, 1'b1, 1'b0, 3);
    $display("backpressure run: 3 words delivered, beat=%0d", beat0);
    tick();

    // ap_start held through done: one IDLE cycle, then a new run with new scale.
    w[0] = 32'h1E000005;
    ap_start = 1'b1; scale = 8'd7; out_ack = 1'b1;
    tick();
    chk_ctrl("hold_run1", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    in_value = w[0]; in_last = 1'b1; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    chk_out("hold_out1", 1'b1, model(w[0], 8'd7, 1, 1'b0), model(w[0], 8'd7, 4, 1'b1), 1'b1);
    tick();
    chk_ctrl("hold_done", 1'b1, 1'b0, 1'b1, 1'b0, 1);
    scale = 8'd9;
    tick();
    ap_start = 1'b0;
    chk_ctrl("hold_run2", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    chk_out("hold_out2", 1'b1, model(w[0], 8'd9, 1, 1'b0), model(w[0], 8'd9, 4, 1'b1), 1'b1);
    tick();
    chk_ctrl("hold_done2", 1'b1, 1'b0, 1'b1, 1'b0, 1);
    $display("restart run: scale 7 then 9, out0=%0h", model(w[0], 8'd9, 1, 1'b0));
    tick();

    // Reset with two words buffered and a nonzero beat count.
    out_ack = 1'b0;
    start_run(8'd4);
    in_value = 32'h00000001; in_last = 1'b0; in_vld = 1'b1;
    tick();
    in_value = 32'h00000002;
    tick();
    in_vld = 1'b0; out_ack = 1'b1;
    tick();
    out_ack = 1'b0; in_value = 32'h00000003; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    chk_ctrl("prerst", 1'b0, 1'b0, 1'b0, 1'b0, 1);
    chk_out("prerst", 1'b1, 32'h08, 32'h08, 1'b0);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    chk_ctrl("midrst", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk_out("midrst", 1'b0, 32'h0, 32'h0, 1'b0);
    out_ack = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      chk_ctrl("postrst", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    end
    $display("mid-run reset: buffered words discarded");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
